sample_capture_dumper: RTL and testbench
========================================

# sample_capture_dumper

Parametrised multi-channel capture-and-dump engine for bring-up of the sigma-delta converters. On a UART command byte it stores `DEPTH` frames of `NUM_CHANNELS` samples into on-chip RAM. It then streams the frames out as uppercase hex ASCII text, one line per frame, through a byte-wide valid/ready interface. It sits between the converter outputs (for example `sigma_delta_adc.adc_output`/`adc_valid`) and the `uart` block in hardware-test tops.

## Interface

- `SAMPLE_BITLEN`, 24: bits per channel sample, 1..32; `HEX_DIGITS` = ceil(SAMPLE_BITLEN/4), derived.
- `NUM_CHANNELS`, 1: channels captured per frame, 1..8.
- `DEPTH`, 4096: frames per capture, power of two ≥ 2.
- `DECIMATE`, 1: store every DECIMATE-th accepted frame, 1..65535.
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sample_data`  in  NUM_CHANNELS*SAMPLE_BITLEN  channel c occupies bits [c*SAMPLE_BITLEN +: SAMPLE_BITLEN].
- `sample_valid`  in  1  one-cycle strobe; all channels are valid together.
- `rx_data`  in  8  command byte from the UART receiver.
- `rx_valid`  in  1  command byte present.
- `rx_ready`  out  1  command byte accepted.
- `tx_data`  out  8  ASCII byte to the UART transmitter.
- `tx_valid`  out  1  tx_data valid.
- `tx_ready`  in  1  transmitter accepts the byte.
- `capturing`  out  1  high while in CAPTURE.
- `busy`  out  1  high in CAPTURE or DUMP.
- `done`  out  1  one-cycle pulse when a dump completes.

## Operation

- States: IDLE, CAPTURE, DUMP. Internal flag `have_capture` is set when a capture completes.
- Commands are taken on `rx_valid & rx_ready`. `rx_ready` is 1 in every state from the first clock after reset release. Matching is case-insensitive.
  - `s`/`S` in IDLE: clear `have_capture`, frame index 0, decimation counter 0, enter CAPTURE.
  - `d`/`D` in IDLE with `have_capture`=1: enter DUMP at frame 0.
  - `x`/`X` in CAPTURE: go to IDLE with `have_capture` left at 0.
  - `x`/`X` in DUMP: finish the byte currently offered (`tx_valid` never drops before its handshake), then go to IDLE. No `done` pulse. `have_capture` is kept.
  - All other bytes, and commands given in the wrong state, are consumed and ignored.
- CAPTURE: each `sample_valid` advances a decimation counter 0..DECIMATE-1. A frame is written to RAM only when the counter is 0.
  - After storing frame DEPTH-1: set `have_capture` and enter DUMP at frame 0. There is no stop in IDLE.
- RAM: DEPTH × (NUM_CHANNELS*SAMPLE_BITLEN), one write port, synchronous read with 1-cycle latency.
- DUMP line format for each frame, in this order:
  - For each channel 0..N-1: HEX_DIGITS digits, MSB nibble first. The sample is zero-extended to 4*HEX_DIGITS bits.
  - Between channels: `,` (0x2C).
  - Line end: LF (0x0A), then CR (0x0D).
- Digit encoding: nibble <10 → nibble+0x30; otherwise nibble+0x37.
- Bytes per line = N*HEX_DIGITS + (N-1) + 2. Total bytes per dump = DEPTH × bytes per line.
- After the CR of frame DEPTH-1 is accepted: pulse `done` and enter IDLE.
- `sample_valid` outside CAPTURE is ignored.

## Timing

- Reset, asynchronous on `rst_n`=0: state IDLE; all counters 0; `have_capture`=0. Outputs: `tx_valid`=0, `tx_data`=0, `rx_ready`=0, `capturing`=0, `busy`=0, `done`=0.
- `s` accepted at cycle T → `capturing`=`busy`=1 at T+1. A `sample_valid` at T+1 or later is eligible as frame 0; a strobe at T is not.
- A `sample_valid` that stores the final frame at cycle C → `capturing`=0 at C+1, DUMP starts at C+1, first `tx_valid` no later than C+3.
- While `tx_valid`=1 and `tx_ready`=0, `tx_data` is held stable.
- After a handshake, the next byte may be offered in the following cycle. Sustained throughput is one byte per cycle when `tx_ready`=1.
- `done` is high in the cycle after the final CR handshake, together with `busy`=0.
- `rst_n` asserted mid-CAPTURE or mid-DUMP: immediate return to reset values. RAM contents are don't-care, and `d` is ignored until a new capture completes.

## Test plan

- N=1, W=24, DEPTH=4, DECIMATE=1; `s`, then samples 0x000001, 0x00ABCD, 0xFFFFFF, 0x123456 → bytes "000001\n\r00ABCD\n\rFFFFFF\n\r123456\n\r" (32 bytes), `done` pulse, `busy`=0.
- N=2, W=10, DEPTH=2; frames {0x3FF, 0x00A}, {0x155, 0x200} → "3FF,00A\n\r155,200\n\r".
- DECIMATE=3, DEPTH=2, samples 0..7 → stored frames 0 and 3. Random `tx_ready` backpressure → identical byte stream, `tx_data` stable during stalls.
- `x` in the middle of DUMP → byte in flight completes, `tx_valid`=0 thereafter, no `done`. A following `d` replays the full dump from frame 0.
- `d` after reset → ignored. `s` during DUMP → ignored. `S` accepted in IDLE → capture starts.
- `rst_n` low for 1 cycle mid-CAPTURE → all outputs 0 asynchronously. A following `d` is ignored, and a fresh `s` capture dumps correctly.

Source files
------------

// File: rtl/sample_capture_dumper.sv
// Captures DEPTH frames of NUM_CHANNELS samples on a UART command and
// streams them back as uppercase hex ASCII, one LF/CR-terminated line per frame.
module sample_capture_dumper #(
   parameter int unsigned SAMPLE_BITLEN = 24,
   parameter int unsigned NUM_CHANNELS  = 1,
   parameter int unsigned DEPTH         = 4096,
   parameter int unsigned DECIMATE      = 1
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [NUM_CHANNELS*SAMPLE_BITLEN-1:0] sample_data,
   input  logic                                  sample_valid,
   input  logic [7:0]                            rx_data,
   input  logic                                  rx_valid,
   output logic                                  rx_ready,
   output logic [7:0]                            tx_data,
   output logic                                  tx_valid,
   input  logic                                  tx_ready,
   output logic                                  capturing,
   output logic                                  busy,
   output logic                                  done
);

   localparam int unsigned HEX_DIGITS = (SAMPLE_BITLEN + 3) / 4;
   localparam int unsigned DATA_W     = NUM_CHANNELS * SAMPLE_BITLEN;
   localparam int unsigned NIB_W      = 4 * HEX_DIGITS;
   localparam int unsigned ADDR_W     = $clog2(DEPTH);
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned DEC_W      = 16;

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DUMP} state_t;
   typedef enum logic [1:0] {PH_DIGIT, PH_COMMA, PH_LF, PH_CR} phase_t;

   state_t              state;
   phase_t              phase;
   logic                have_capture;
   logic [ADDR_W-1:0]   frm;
   logic [DEC_W-1:0]    dec;
   logic [DATA_W-1:0]   line_q;
   logic                line_ok;
   logic [CNT_W-1:0]    ch;
   logic [CNT_W-1:0]    dg;
   logic                fin;
   logic                stop_pend;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   rd_q;

   logic [7:0]          cmd_lc_c;
   logic                take_c, cmd_s_c, cmd_d_c, cmd_x_c, hs_c, store_c;
   logic [ADDR_W-1:0]   rd_addr_c;
   logic [SAMPLE_BITLEN-1:0] sample_c;
   logic [NIB_W-1:0]    nib_ext_c;
   logic [3:0]          nib_c;
   logic [7:0]          byte_c;

   // Command decode, RAM addressing and next ASCII byte
   always_comb begin
      cmd_lc_c  = rx_data | 8'h20;
      take_c    = rx_valid & rx_ready;
      cmd_s_c   = take_c && (cmd_lc_c == 8'h73);
      cmd_d_c   = take_c && (cmd_lc_c == 8'h64);
      cmd_x_c   = take_c && (cmd_lc_c == 8'h78);
      hs_c      = tx_valid & tx_ready;
      store_c   = (state == S_CAPTURE) && sample_valid && (dec == '0) && !cmd_x_c;
      // Prefetch the following frame while the current line is being emitted
      rd_addr_c = (state == S_DUMP && line_ok) ? frm + ADDR_W'(1) : '0;
      sample_c  = SAMPLE_BITLEN'(line_q >> (32'(ch) * SAMPLE_BITLEN));
      nib_ext_c = NIB_W'(sample_c);
      nib_c     = 4'(nib_ext_c >> (4 * (HEX_DIGITS - 1 - 32'(dg))));
      byte_c    = 8'h00;
      case (phase)
         PH_DIGIT: byte_c = (nib_c < 4'd10) ? 8'h30 + 8'(nib_c) : 8'h37 + 8'(nib_c);
         PH_COMMA: byte_c = 8'h2C;
         PH_LF:    byte_c = 8'h0A;
         PH_CR:    byte_c = 8'h0D;
         default:  byte_c = 8'h00;
      endcase
   end

   // Sample RAM: single write port, registered read
   always_ff @(posedge clk) begin
      if (store_c) mem[frm] <= sample_data;
      rd_q <= mem[rd_addr_c];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         phase        <= PH_DIGIT;
         have_capture <= 1'b0;
         frm          <= '0;
         dec          <= '0;
         line_q       <= '0;
         line_ok      <= 1'b0;
         ch           <= '0;
         dg           <= '0;
         fin          <= 1'b0;
         stop_pend    <= 1'b0;
         rx_ready     <= 1'b0;
         tx_data      <= 8'h00;
         tx_valid     <= 1'b0;
         capturing    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         rx_ready <= 1'b1;
         done     <= 1'b0;
         if (state != S_DUMP) begin
            phase     <= PH_DIGIT;
            line_ok   <= 1'b0;
            ch        <= '0;
            dg        <= '0;
            fin       <= 1'b0;
            stop_pend <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (cmd_s_c) begin
                  have_capture <= 1'b0;
                  frm          <= '0;
                  dec          <= '0;
                  capturing    <= 1'b1;
                  busy         <= 1'b1;
                  state        <= S_CAPTURE;
               end else if (cmd_d_c && have_capture) begin
                  frm   <= '0;
                  busy  <= 1'b1;
                  state <= S_DUMP;
               end
            end
            S_CAPTURE: begin
               if (cmd_x_c) begin
                  capturing <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end else if (sample_valid) begin
                  dec <= (dec == DEC_W'(DECIMATE - 1)) ? '0 : dec + DEC_W'(1);
                  if (dec == '0) begin
                     if (frm == ADDR_W'(DEPTH - 1)) begin
                        have_capture <= 1'b1;
                        capturing    <= 1'b0;
                        frm          <= '0;
                        state        <= S_DUMP;
                     end else begin
                        frm <= frm + ADDR_W'(1);
                     end
                  end
               end
            end
            S_DUMP: begin
               // An abort lets the byte on offer complete its handshake first
               if (cmd_x_c || stop_pend) begin
                  if (!tx_valid || hs_c) begin
                     tx_valid <= 1'b0;
                     busy     <= 1'b0;
                     state    <= S_IDLE;
                  end else begin
                     stop_pend <= 1'b1;
                  end
               end else if (fin && hs_c) begin
                  tx_valid <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= S_IDLE;
               end else if (!line_ok) begin
                  line_q  <= rd_q;
                  line_ok <= 1'b1;
               end else if (!fin && (!tx_valid || tx_ready)) begin
                  tx_data  <= byte_c;
                  tx_valid <= 1'b1;
                  case (phase)
                     PH_DIGIT: begin
                        if (dg == CNT_W'(HEX_DIGITS - 1)) begin
                           dg    <= '0;
                           phase <= (ch == CNT_W'(NUM_CHANNELS - 1)) ? PH_LF : PH_COMMA;
                        end else begin
                           dg <= dg + CNT_W'(1);
                        end
                     end
                     PH_COMMA: begin
                        ch    <= ch + CNT_W'(1);
                        phase <= PH_DIGIT;
                     end
                     PH_LF: phase <= PH_CR;
                     PH_CR: begin
                        phase <= PH_DIGIT;
                        ch    <= '0;
                        if (frm == ADDR_W'(DEPTH - 1)) begin
                           fin <= 1'b1;
                        end else begin
                           frm    <= frm + ADDR_W'(1);
                           line_q <= rd_q;
                        end
                     end
                     default: phase <= PH_DIGIT;
                  endcase
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sample_capture_dumper.sv
// Directed bench for sample_capture_dumper: instance A (N=1, W=24, DEPTH=4) and
// instance B (N=2, W=10, DEPTH=2, DECIMATE=3) share clock and reset.
module tb_sample_capture_dumper;

   typedef struct packed {
      logic [7:0] cmd;
      logic       cap;
      logic       bsy;
   } cmd_vec_t;

   typedef struct {
      logic [3:0][23:0] smp;
      string            exp;
      bit               rnd;
   } a_vec_t;

   typedef struct {
      logic [3:0][19:0] f;
      string            exp;
      bit               rnd;
   } b_vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] a_sd = '0;
   logic [19:0] b_sd = '0;
   logic [1:0]  sample_valid = '0;
   logic [7:0]  rx_data [2];
   logic [1:0]  rx_valid = '0;
   logic [1:0]  rx_ready;
   logic [7:0]  tx_data [2];
   logic [1:0]  tx_valid;
   logic [1:0]  tx_ready = '0;
   logic [1:0]  capturing;
   logic [1:0]  busy;
   logic [1:0]  done;

   int checks = 0;
   int errors = 0;
   logic [7:0] a_got [$];
   logic [7:0] b_got [$];
   int   done_cnt [2];
   int   stab_err [2];
   logic stall_v [2];
   logic [7:0] stall_d [2];

   always #5 clk = ~clk;

   sample_capture_dumper #(.SAMPLE_BITLEN(24), .NUM_CHANNELS(1), .DEPTH(4), .DECIMATE(1)) u_a (
      .clk(clk), .rst_n(rst_n), .sample_data(a_sd), .sample_valid(sample_valid[0]),
      .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
      .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
      .capturing(capturing[0]), .busy(busy[0]), .done(done[0]));

   sample_capture_dumper #(.SAMPLE_BITLEN(10), .NUM_CHANNELS(2), .DEPTH(2), .DECIMATE(3)) u_b (
      .clk(clk), .rst_n(rst_n), .sample_data(b_sd), .sample_valid(sample_valid[1]),
      .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
      .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
      .capturing(capturing[1]), .busy(busy[1]), .done(done[1]));

   // Byte collection, stall-stability and done-pulse monitors (mid-cycle)
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (tx_valid[i] && tx_ready[i]) begin
            if (i == 0) a_got.push_back(tx_data[i]);
            else        b_got.push_back(tx_data[i]);
         end
         if (stall_v[i] && (!tx_valid[i] || tx_data[i] != stall_d[i])) stab_err[i]++;
         stall_v[i] = tx_valid[i] && !tx_ready[i] && rst_n;
         stall_d[i] = tx_data[i];
         if (done[i]) done_cnt[i]++;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cmd(input int inst, input logic [7:0] c);
      rx_data[inst]  = c;
      rx_valid[inst] = 1'b1;
      tick(1);
      rx_valid[inst] = 1'b0;
   endtask

   task automatic clear(input int inst);
      if (inst == 0) a_got.delete();
      else           b_got.delete();
      done_cnt[inst] = 0;
      stab_err[inst] = 0;
   endtask

   task automatic chk_bytes(input int inst, input string exp, input string name, input bit full);
      logic [7:0] q [$];
      if (inst == 0) q = a_got;
      else           q = b_got;
      if (full) chk({name, " length"}, 32'(q.size()), 32'(exp.len()));
      for (int i = 0; i < exp.len() && i < q.size(); i++)
         chk($sformatf("%s byte %0d", name, i), 32'(q[i]), 32'(exp[i]));
   endtask

   task automatic run_dump(input int inst, input string exp, input bit rnd,
                           input logic [7:0] inj, input string name);
      bit fin = 1'b0;
      for (int it = 0; it < 3000 && !fin; it++) begin
         tx_ready[inst] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (inj != 8'h00 && it == 5) begin
            rx_data[inst]  = inj;
            rx_valid[inst] = 1'b1;
         end else begin
            rx_valid[inst] = 1'b0;
         end
         tick(1);
         if (!busy[inst]) fin = 1'b1;
      end
      rx_valid[inst] = 1'b0;
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: busy still 1 after 3000 cycles, required 0", name);
      end
      chk({name, " done with busy low"}, 32'(done[inst]), 32'd1);
      tick(1);
      chk({name, " done single pulse"}, 32'(done[inst]), 32'd0);
      tx_ready[inst] = 1'b0;
      chk_bytes(inst, exp, name, 1'b1);
      chk({name, " tx stable in stall"}, 32'(stab_err[inst]), 32'd0);
      chk({name, " done count"}, 32'(done_cnt[inst]), 32'd1);
   endtask

   // Capture on A with a junk strobe coinciding with the accepted 's'
   task automatic capture_a(input a_vec_t v, input string name);
      clear(0);
      tx_ready[0] = 1'b0;
      a_sd = 24'hDEAD00;
      sample_valid[0] = 1'b1;
      cmd(0, 8'h73);
      sample_valid[0] = 1'b0;
      chk({name, " capturing after s"}, 32'(capturing[0]), 32'd1);
      chk({name, " busy after s"}, 32'(busy[0]), 32'd1);
      for (int k = 0; k < 4; k++) begin
         a_sd = v.smp[k];
         sample_valid[0] = 1'b1;
         tick(1);
         sample_valid[0] = 1'b0;
         if (k < 3) tick(1);
      end
      chk({name, " capturing after last"}, 32'(capturing[0]), 32'd0);
      chk({name, " busy after last"}, 32'(busy[0]), 32'd1);
      tick(2);
      chk({name, " tx_valid by C+3"}, 32'(tx_valid[0]), 32'd1);
      run_dump(0, v.exp, v.rnd, 8'h00, name);
   endtask

   task automatic capture_b(input b_vec_t v, input string name);
      clear(1);
      tx_ready[1] = 1'b0;
      b_sd = 20'hFFFFF;
      sample_valid[1] = 1'b1;
      cmd(1, 8'h53);
      sample_valid[1] = 1'b0;
      chk({name, " capturing after S"}, 32'(capturing[1]), 32'd1);
      for (int k = 0; k < 4; k++) begin
         b_sd = v.f[k];
         sample_valid[1] = 1'b1;
         tick(1);
         sample_valid[1] = 1'b0;
      end
      chk({name, " capturing after last"}, 32'(capturing[1]), 32'd0);
      tick(2);
      chk({name, " tx_valid by C+3"}, 32'(tx_valid[1]), 32'd1);
      run_dump(1, v.exp, v.rnd, 8'h00, name);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_vec_t cv [10];
      a_vec_t   av [2];
      b_vec_t   bv [2];
      logic [7:0] cur;

      cv[0] = '{8'h64, 1'b0, 1'b0};  // d with no capture
      cv[1] = '{8'h51, 1'b0, 1'b0};  // unknown byte
      cv[2] = '{8'h58, 1'b0, 1'b0};  // X in IDLE
      cv[3] = '{8'h53, 1'b1, 1'b1};  // S starts capture
      cv[4] = '{8'h64, 1'b1, 1'b1};  // d ignored in CAPTURE
      cv[5] = '{8'h73, 1'b1, 1'b1};  // s ignored in CAPTURE
      cv[6] = '{8'h78, 1'b0, 1'b0};  // x aborts capture
      cv[7] = '{8'h44, 1'b0, 1'b0};  // D ignored, no capture kept
      cv[8] = '{8'h73, 1'b1, 1'b1};
      cv[9] = '{8'h58, 1'b0, 1'b0};

      av[0].smp = {24'h123456, 24'hFFFFFF, 24'h00ABCD, 24'h000001};
      av[0].exp = "000001\n\r00ABCD\n\rFFFFFF\n\r123456\n\r";
      av[0].rnd = 1'b0;
      av[1].smp = {24'h987654, 24'h0F0F0F, 24'h000000, 24'hABCDEF};
      av[1].exp = "ABCDEF\n\r000000\n\r0F0F0F\n\r987654\n\r";
      av[1].rnd = 1'b1;

      bv[0].f   = {{10'h200, 10'h155}, {10'h111, 10'h222}, {10'h0AB, 10'h0CD}, {10'h00A, 10'h3FF}};
      bv[0].exp = "3FF,00A\n\r155,200\n\r";
      bv[0].rnd = 1'b1;
      bv[1].f   = {{10'h013, 10'h003}, {10'h012, 10'h002}, {10'h011, 10'h001}, {10'h010, 10'h000}};
      bv[1].exp = "000,010\n\r003,013\n\r";
      bv[1].rnd = 1'b0;

      rx_data[0] = 8'h00;
      rx_data[1] = 8'h00;
      for (int i = 0; i < 2; i++) begin
         done_cnt[i] = 0;
         stab_err[i] = 0;
         stall_v[i]  = 1'b0;
         stall_d[i]  = 8'h00;
      end

      // Reset values
      tick(3);
      chk("reset tx_valid", 32'(tx_valid[0]), 32'd0);
      chk("reset tx_data", 32'(tx_data[0]), 32'd0);
      chk("reset rx_ready", 32'(rx_ready[0]), 32'd0);
      chk("reset capturing", 32'(capturing[0]), 32'd0);
      chk("reset busy", 32'(busy[0]), 32'd0);
      chk("reset done", 32'(done[0]), 32'd0);
      rst_n = 1'b1;
      tick(1);
      chk("rx_ready after reset", 32'(rx_ready[0]), 32'd1);

      // Command response table
      for (int i = 0; i < 10; i++) begin
         cmd(0, cv[i].cmd);
         chk($sformatf("cmd %0d capturing", i), 32'(capturing[0]), 32'(cv[i].cap));
         chk($sformatf("cmd %0d busy", i), 32'(busy[0]), 32'(cv[i].bsy));
      end
      tick(2);
      chk("no tx after ignored d", 32'(tx_valid[0]), 32'd0);

      for (int v = 0; v < 2; v++) capture_a(av[v], $sformatf("A vec %0d", v));

      // Abort in mid-dump: in-flight byte completes, no done, then full replay
      clear(0);
      tx_ready[0] = 1'b0;
      cmd(0, 8'h64);
      tx_ready[0] = 1'b1;
      tick(8);
      tx_ready[0] = 1'b0;
      tick(2);
      cur = tx_data[0];
      chk("abort byte offered", 32'(tx_valid[0]), 32'd1);
      cmd(0, 8'h78);
      chk("abort holds tx_valid", 32'(tx_valid[0]), 32'd1);
      chk("abort holds busy", 32'(busy[0]), 32'd1);
      tick(2);
      chk("abort still offered", 32'(tx_valid[0]), 32'd1);
      chk("abort data held", 32'(tx_data[0]), 32'(cur));
      tx_ready[0] = 1'b1;
      tick(1);
      chk("abort tx_valid after hs", 32'(tx_valid[0]), 32'd0);
      chk("abort busy after hs", 32'(busy[0]), 32'd0);
      tick(4);
      chk("abort tx_valid stays low", 32'(tx_valid[0]), 32'd0);
      chk("abort no done", 32'(done_cnt[0]), 32'd0);
      chk("abort stall stable", 32'(stab_err[0]), 32'd0);
      chk("abort partial", 32'(a_got.size() > 0 && a_got.size() < 32), 32'd1);
      if (a_got.size() > 0) chk("abort last byte", 32'(a_got[a_got.size() - 1]), 32'(cur));
      chk_bytes(0, av[1].exp, "abort prefix", 1'b0);

      clear(0);
      tx_ready[0] = 1'b0;
      cmd(0, 8'h44);
      run_dump(0, av[1].exp, 1'b1, 8'h73, "replay with s");
      chk("replay no capture", 32'(capturing[0]), 32'd0);

      for (int v = 0; v < 2; v++) capture_b(bv[v], $sformatf("B vec %0d", v));

      // Asynchronous reset in mid-capture
      clear(0);
      cmd(0, 8'h73);
      a_sd = 24'h111111;
      sample_valid[0] = 1'b1;
      tick(2);
      sample_valid[0] = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst capturing", 32'(capturing[0]), 32'd0);
      chk("async rst busy", 32'(busy[0]), 32'd0);
      chk("async rst rx_ready", 32'(rx_ready[0]), 32'd0);
      chk("async rst tx_data", 32'(tx_data[0]), 32'd0);
      chk("async rst tx_valid", 32'(tx_valid[0]), 32'd0);
      chk("async rst done", 32'(done[0]), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(1);
      cmd(0, 8'h64);
      tick(3);
      chk("d after reset busy", 32'(busy[0]), 32'd0);
      chk("d after reset tx_valid", 32'(tx_valid[0]), 32'd0);
      capture_a(av[0], "post-reset capture");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
